mem_access_master: RTL
======================

// Module: mem_access_master
// PURPOSE
//   Initiator side of the mem_top port (cen/rd/wr/add/din/dout). Accepts host read/write
//   commands over a valid/ready handshake and sequences them onto the memory pins.
//   It also returns read data and owns chip-enable power-down. It replaces the
//   hand-timed stimulus in memory checkers with a cycle-exact driver.
// PARAMETERS
//   AW      12  address width (mem_top add)
//   DW      8   data width (mem_top din/dout)
//   RD_LAT  1   cycles mem_rd is held before mem_dout is sampled; legal range >=1
// PORTS
//   clk        in   1    single clock, all logic on posedge
//   rst        in   1    asynchronous, active-high reset
//   cmd_valid  in   1    host command present
//   cmd_ready  out  1    master can accept a command this cycle
//   cmd_wr     in   1    1=write, 0=read
//   cmd_addr   in   AW   command address
//   cmd_wdata  in   DW   write data; ignored for reads
//   sleep_req  in   1    level request to power memory down (cen high)
//   rsp_valid  out  1    one-cycle pulse, rsp_data holds read result
//   rsp_data   out  DW   captured mem_dout
//   busy       out  1    state != IDLE
//   mem_cen    out  1    memory chip-enable, 1 = disabled/power-down
//   mem_rd     out  1    memory read strobe
//   mem_wr     out  1    memory write strobe
//   mem_add    out  AW   memory address
//   mem_din    out  DW   memory write data
//   mem_dout   in   DW   memory read data
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE, mem_cen=0, mem_rd=0, mem_wr=0,
//   mem_add=0, mem_din=0, rsp_valid=0, rsp_data=0, busy=0. While rst=1, cmd_ready=0.
//   All mem_* outputs are registered; no combinational path from cmd_* to mem_*.
//   cmd_ready = (state==IDLE) & ~sleep_req & ~rst. Accept = cmd_valid & cmd_ready.
//   States:
//     IDLE  -> WR on write accept; -> RD on read accept; -> SLEEP if sleep_req (sleep beats cmd_valid).
//     WR    one cycle: mem_wr=1, mem_add/mem_din = latched cmd; -> IDLE.
//     RD    mem_rd=1, mem_din=0, mem_add latched; held exactly RD_LAT cycles (down-counter,
//           width $clog2(RD_LAT+1)). On last RD edge: rsp_data<=mem_dout, rsp_valid<=1; -> IDLE.
//     SLEEP mem_cen=1, mem_rd=mem_wr=0; held while sleep_req=1; on deassert -> WAKE.
//     WAKE  one cycle: mem_cen=0, cmd_ready=0 (memory settle); -> IDLE.
//   Latency: write accept at edge N -> mem_wr high in cycle N+1. Read accept at edge N ->
//     mem_rd high in cycles N+1..N+RD_LAT. rsp_valid high in cycle N+RD_LAT+1.
//   Throughput: one command per (1 + access length) cycles; cmd_ready is low during WR/RD.
//   Invariants: mem_rd & mem_wr never both 1; neither is 1 while mem_cen=1; rsp_valid
//     only follows a read and never lasts more than one cycle. No response backpressure.
//   sleep_req raised during WR/RD: the access completes (including rsp_valid), then SLEEP.
//   rst mid-access: outputs return to reset values immediately; the in-flight read is
//     dropped and no rsp_valid is generated.
//   Address/data are passed unmodified; no wrap or width conversion.
// STRUCTURE
//   Shared package mem_if_pkg: AW/DW defaults, state encoding (IDLE,WR,RD,SLEEP,WAKE),
//   CMD_READ/CMD_WRITE constants; package also used by the checker bench.
//   Single module; no sub-module needed (latency counter is inline).
// TESTING (bench pairs this with mem_top, vdd=1.8, vss=0)
//   1 Write 0x2AA<=0xAA, 0x6CA<=0xEA, then read 0x6CA -> rsp_valid at accept+RD_LAT+1,
//     rsp_data=0xEA; mem_wr one cycle per write.
//   2 Back-to-back cmd_valid held high, 7 writes then 7 reads (AA,EA,BA,FA,EE,FE,BB)
//     -> cmd_ready low in access cycles; read data in order; no rd/wr overlap.
//   3 sleep_req=1 with cmd_valid=1 in IDLE -> cmd_ready=0, mem_cen=1 next cycle, no strobes.
//     Release -> one WAKE cycle, then read 0xEAA returns 0xEE.
//   4 sleep_req raised in the first RD cycle -> read completes with correct data, then SLEEP.
//   5 rst pulsed mid-read (RD_LAT=3, cycle 2) -> mem_rd=0 and rsp_valid=0 at once; no pulse
//     afterwards; restart in IDLE.
//   6 RD_LAT=1 and RD_LAT=4 builds -> mem_rd width 1 and 4 cycles; response timing matches.

Source files
------------

// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared widths, state encoding and command constants for the mem_top port
package mem_if_pkg;

    localparam int AW_DEF = 12;
    localparam int DW_DEF = 8;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_RD    = 3'd2,
        ST_SLEEP = 3'd3,
        ST_WAKE  = 3'd4
    } state_t;

endpackage

// File: rtl/mem_access_master.sv
// rtl/mem_access_master.sv - sequences host read/write commands onto the mem_top pins
module mem_access_master
    import mem_if_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic          sleep_req,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          busy,
    output logic          mem_cen,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_add,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam int            CW       = $clog2(RD_LAT + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(RD_LAT - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          accept;
    logic          rd_last;

    assign cmd_ready = (state == ST_IDLE) & ~sleep_req & ~rst;
    assign accept    = cmd_valid & cmd_ready;
    assign busy      = (state != ST_IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rd_last = 1'b0;
        case (state)
            // A pending sleep request wins over a command presented in the same cycle.
            ST_IDLE: begin
                if (sleep_req) begin
                    state_n = ST_SLEEP;
                end else if (accept) begin
                    state_n = (cmd_wr == CMD_WRITE) ? ST_WR : ST_RD;
                    cnt_n   = CNT_INIT;
                end
            end
            ST_WR: state_n = ST_IDLE;
            ST_RD: begin
                if (cnt == '0) begin
                    rd_last = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_SLEEP: if (!sleep_req) state_n = ST_WAKE;
            ST_WAKE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Pin outputs are decoded from the next state so they are registered yet cycle-aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mem_cen   <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_add   <= '0;
            mem_din   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            mem_cen   <= (state_n == ST_SLEEP);
            mem_rd    <= (state_n == ST_RD);
            mem_wr    <= (state_n == ST_WR);
            rsp_valid <= rd_last;
            if (rd_last) begin
                rsp_data <= mem_dout;
            end
            if (accept) begin
                mem_add <= cmd_addr;
                mem_din <= (cmd_wr == CMD_WRITE) ? cmd_wdata : '0;
            end
        end
    end

endmodule
